udp_tx_payload_packer: RTL and testbench

- Store-and-forward byte packer on the user side of the UDP example's transmit path.
- Collects a user byte stream into a frame buffer and latches the frame length.
- Requests a UDP send from the stack, then streams bytes out as the stack pulls them.
- Output signals (tx_data_valid 1b, tx_data 8b, tx_len 16b) have the same shapes the debug probes capture on the receive side, so a loopback can be checked on the logic analyzer.

---
 rtl/udp_tx_pkg.sv | 13 +
 rtl/udp_tx_buf.sv | 34 +++
 rtl/udp_tx_payload_packer.sv | 152 +++++++++++++++
 tb/tb_udp_tx_payload_packer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_pkg.sv
// Shared state encoding and sizing constants for the UDP transmit payload packer.
package udp_tx_pkg;

    typedef enum logic [1:0] {
        FILL,
        REQ,
        SEND
    } udp_tx_state_e;

    localparam int unsigned UDP_MAX_PAYLOAD = 1472;
    localparam int unsigned LEN_W           = 16;

endpackage

// File: rtl/udp_tx_buf.sv
// Frame buffer: one write port, one registered read port, sized for block RAM inference.
module udp_tx_buf #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [0:(2**ADDR_W)-1];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/udp_tx_payload_packer.sv
// Store-and-forward packer: buffers a user byte frame, requests a UDP send, streams it out.
// Optional idle flush of partial frames when UDP_TX_TIMEOUT_EN is defined.
module udp_tx_payload_packer
    import udp_tx_pkg::*;
#(
    parameter int unsigned MAX_LEN     = UDP_MAX_PAYLOAD,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             tx_req,
    input  logic             tx_ack,
    output logic [LEN_W-1:0] tx_len,
    input  logic             tx_data_req,
    output logic             tx_data_valid,
    output logic [7:0]       tx_data,
    output logic             busy
);

    if (MAX_LEN > (2**ADDR_W) || MAX_LEN == 0 || TIMEOUT_CYC == 0) begin : g_bad_param
        $error("udp_tx_payload_packer: illegal MAX_LEN/ADDR_W/TIMEOUT_CYC");
    end

    udp_tx_state_e     state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  tx_len_q, tx_len_d;
    logic              in_ready_q, in_ready_d;
    logic              tx_req_q, tx_req_d;
    logic              tx_data_valid_q, tx_data_valid_d;
    logic              busy_q, busy_d;
    logic              accept, wr_en, rd_en;

`ifdef UDP_TX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        tx_len_d        = tx_len_q;
        tx_req_d        = tx_req_q;
        tx_data_valid_d = 1'b0;
        wr_en           = 1'b0;
        rd_en           = 1'b0;
        accept          = in_valid && in_ready_q && (state_q == FILL);
`ifdef UDP_TX_TIMEOUT_EN
        idle_cnt_d      = '0;
`endif
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (in_last || wr_ptr_q == ADDR_W'(MAX_LEN - 1)) begin
                        tx_len_d = LEN_W'(wr_ptr_q) + 1'b1;
                        tx_req_d = 1'b1;
                        state_d  = REQ;
                    end
                end
`ifdef UDP_TX_TIMEOUT_EN
                else if (wr_ptr_q != '0) begin
                    if (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        tx_len_d = LEN_W'(wr_ptr_q);
                        tx_req_d = 1'b1;
                        state_d  = REQ;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
`endif
            end
            REQ: begin
                if (tx_ack) begin
                    tx_req_d = 1'b0;
                    rd_ptr_d = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (tx_data_req && (LEN_W'(rd_ptr_q) < tx_len_q)) begin
                    rd_en           = 1'b1;
                    rd_ptr_d        = rd_ptr_q + 1'b1;
                    tx_data_valid_d = 1'b1;
                end
                // All reads issued and the final byte is on tx_data this cycle.
                if (tx_data_valid_q && (LEN_W'(rd_ptr_q) == tx_len_q)) begin
                    wr_ptr_d = '0;
                    state_d  = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        in_ready_d = (state_q == FILL) && (state_d == FILL);
        busy_d     = (state_d != FILL) || (wr_ptr_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= FILL;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            tx_len_q        <= '0;
            in_ready_q      <= 1'b0;
            tx_req_q        <= 1'b0;
            tx_data_valid_q <= 1'b0;
            busy_q          <= 1'b0;
`ifdef UDP_TX_TIMEOUT_EN
            idle_cnt_q      <= '0;
`endif
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            tx_len_q        <= tx_len_d;
            in_ready_q      <= in_ready_d;
            tx_req_q        <= tx_req_d;
            tx_data_valid_q <= tx_data_valid_d;
            busy_q          <= busy_d;
`ifdef UDP_TX_TIMEOUT_EN
            idle_cnt_q      <= idle_cnt_d;
`endif
        end
    end

    udp_tx_buf #(
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (tx_data)
    );

    assign in_ready      = in_ready_q;
    assign tx_req        = tx_req_q;
    assign tx_len        = tx_len_q;
    assign tx_data_valid = tx_data_valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_udp_tx_payload_packer.sv
// Directed self-checking bench for udp_tx_payload_packer (honours UDP_TX_TIMEOUT_EN).
module tb_udp_tx_payload_packer;

    localparam int unsigned MAX_LEN = 1472;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        tx_ack = 1'b0;
    logic        tx_data_req = 1'b0;
    logic        in_ready, tx_req, tx_data_valid, busy;
    logic [15:0] tx_len;
    logic [7:0]  tx_data;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned t;
    logic [7:0]  rx_data[$];
    logic [7:0]  exp_q[$];
    int unsigned rx_cyc[$];
    int unsigned req_cyc[$];

    udp_tx_payload_packer #(
        .MAX_LEN     (MAX_LEN),
        .ADDR_W      (11),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .tx_req        (tx_req),
        .tx_ack        (tx_ack),
        .tx_len        (tx_len),
        .tx_data_req   (tx_data_req),
        .tx_data_valid (tx_data_valid),
        .tx_data       (tx_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_data_valid === 1'b1) begin
            rx_data.push_back(tx_data);
            rx_cyc.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_queues();
        rx_data.delete();
        rx_cyc.delete();
        req_cyc.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_in_ready"}, 32'(in_ready), 0);
        check_val({tag, "_tx_req"}, 32'(tx_req), 0);
        check_val({tag, "_tx_len"}, 32'(tx_len), 0);
        check_val({tag, "_tx_valid"}, 32'(tx_data_valid), 0);
        check_val({tag, "_tx_data"}, 32'(tx_data), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic last);
        int unsigned w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) check_val("push_timeout", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_req(input int unsigned limit, output int unsigned n);
        n = 0;
        while (tx_req !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (tx_req !== 1'b1) check_val("req_timeout", 32'(tx_req), 1);
    endtask

    task automatic ack_after(input int unsigned dly);
        repeat (dly) @(negedge clk);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
    endtask

    task automatic pull(input int unsigned n, input logic toggle);
        for (int unsigned i = 0; i < n; i++) begin
            tx_data_req = toggle ? ~i[0] : 1'b1;
            if (tx_data_req) req_cyc.push_back(cyc);
            @(negedge clk);
        end
        tx_data_req = 1'b0;
    endtask

    task automatic check_rx(input string tag);
        check_val({tag, "_count"}, 32'(rx_data.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_data.size(); i++)
            check_val({tag, "_byte"}, 32'(rx_data[i]), 32'(exp_q[i]));
    endtask

    task automatic serve(input int unsigned exp_len, input string tag, input int unsigned n_pull);
        int unsigned n;
        wait_req(200, n);
        check_val({tag, "_len"}, 32'(tx_len), exp_len);
        check_val({tag, "_ready_lo"}, 32'(in_ready), 0);
        ack_after(3);
        check_val({tag, "_req_lo"}, 32'(tx_req), 0);
        pull(n_pull, 1'b0);
        repeat (3) @(negedge clk);
        check_rx(tag);
        check_val({tag, "_ready_hi"}, 32'(in_ready), 1);
        check_val({tag, "_busy_lo"}, 32'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_ready", 32'(in_ready), 1);

        // 10-byte frame, continuous pull with two surplus requests
        clear_queues();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(8'(i));
            push_byte(8'(i), (i == 9));
        end
        serve(10, "t1", 12);

        // stray ack in FILL, then single-byte frame
        clear_queues();
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        @(negedge clk);
        check_val("t2_stray_ack_req", 32'(tx_req), 0);
        check_val("t2_stray_ack_busy", 32'(busy), 0);
        exp_q.push_back(8'hA5);
        push_byte(8'hA5, 1'b1);
        serve(1, "t2", 3);

        // MAX_LEN+1 bytes with no in_last: split, 1473rd byte held off
        clear_queues();
        for (int i = 0; i < MAX_LEN; i++) exp_q.push_back(8'(i));
        fork
            begin
                for (int i = 0; i <= MAX_LEN; i++) push_byte(8'(i), 1'b0);
            end
            begin
                wait_req(3000, t);
                check_val("t3_len", 32'(tx_len), MAX_LEN);
                repeat (5) @(negedge clk);
                check_val("t3_held_ready", 32'(in_ready), 0);
                check_val("t3_held_busy", 32'(busy), 1);
                ack_after(3);
                pull(MAX_LEN + 2, 1'b0);
                repeat (3) @(negedge clk);
                check_rx("t3");
            end
        join
        clear_queues();
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'h77);
        push_byte(8'h77, 1'b1);
        serve(2, "t3b", 4);

        // toggled pull on a 4-byte frame
        clear_queues();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'(8'h11 * (i + 1)));
            push_byte(8'(8'h11 * (i + 1)), (i == 3));
        end
        wait_req(200, t);
        check_val("t4_len", 32'(tx_len), 4);
        ack_after(1);
        pull(8, 1'b1);
        repeat (3) @(negedge clk);
        check_rx("t4");
        check_val("t4_valid_cnt", 32'(rx_cyc.size()), 4);
        for (int i = 0; i < rx_cyc.size() && i < req_cyc.size(); i++)
            check_val("t4_valid_lat", rx_cyc[i], req_cyc[i] + 1);
        check_val("t4_ready_hi", 32'(in_ready), 1);

        // reset in SEND after 3 of 8 bytes
        clear_queues();
        for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i), (i == 7));
        wait_req(200, t);
        ack_after(2);
        pull(3, 1'b0);
        @(negedge clk);
        check_val("t5_pre_cnt", 32'(rx_data.size()), 3);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outs("t5_rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_val("t5_ready", 32'(in_ready), 1);
        clear_queues();
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h3C);
        push_byte(8'h5A, 1'b0);
        push_byte(8'h3C, 1'b1);
        serve(2, "t5b", 4);

        // 5 bytes then idle
        clear_queues();
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
            push_byte(8'(i), 1'b0);
        end
`ifdef UDP_TX_TIMEOUT_EN
        wait_req(100, t);
        check_val("t6_timeout_cycles", t, 16);
        serve(5, "t6", 7);
`else
        repeat (40) @(negedge clk);
        check_val("t6_no_req", 32'(tx_req), 0);
        check_val("t6_busy", 32'(busy), 1);
        check_val("t6_ready", 32'(in_ready), 1);
        exp_q.push_back(8'h06);
        push_byte(8'h06, 1'b1);
        serve(6, "t6", 8);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
